// File: rtl/gf180mcu_osu_sc_gp9t3v3__clkdiv_if.sv
// Bundle of the divider's control and clock-output signals.
// master: the controlling block (drives EN/DIV, observes Y/TICK/ACK).
// slave:  the divider itself.
`timescale 1ns/10ps

interface gf180mcu_osu_sc_gp9t3v3__clkdiv_if #(
  parameter int unsigned WIDTH = 4
);
  logic             EN;
  logic [WIDTH-1:0] DIV;
  logic             Y;
  logic             TICK;
  logic             ACK;

  modport master (
    output EN,
    output DIV,
    input  Y,
    input  TICK,
    input  ACK
  );

  modport slave (
    input  EN,
    input  DIV,
    output Y,
    output TICK,
    output ACK
  );
endinterface

// File: rtl/gf180mcu_osu_sc_gp9t3v3__clkdiv.sv
// Programmable glitch-free clock divider.
// Output period is 2*(DIV+1) CLK cycles at 50 % duty. A new ratio is latched
// only on the falling toggle, and stopping while Y is high drains the current
// high phase so no truncated pulse is ever produced (reset excepted).
// Optional feature macro: GF180MCU_OSU_SC_CLKDIV_SYNC_EN -- when defined, EN
// passes through a two-flop synchronizer and is seen two edges late.
`timescale 1ns/10ps

module gf180mcu_osu_sc_gp9t3v3__clkdiv #(
  parameter int unsigned WIDTH = 4
) (
  input  logic CLK,
  input  logic R,
  gf180mcu_osu_sc_gp9t3v3__clkdiv_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             y_q, y_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             en_s;
  logic             wrap;

`ifdef GF180MCU_OSU_SC_CLKDIV_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer for an EN that may be asynchronous to CLK
  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], bus.EN};
    end
  end

  assign en_s = sync_q[1];
`else
  assign en_s = bus.EN;
`endif

  assign wrap = (cnt_q == div_q);

  // Next-state, counter, ratio latch and output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    y_d     = y_q;
    tick_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        y_d   = 1'b0;
        cnt_d = '0;
        if (en_s) begin
          state_d = RUN;
          div_d   = bus.DIV;
        end
      end

      RUN: begin
        if (!en_s && !y_q) begin
          // Stopping while low: leave before any pending rise can happen.
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          // Stopping while high keeps counting so the high phase completes.
          if (!en_s) begin
            state_d = DRAIN;
          end
          if (!wrap) begin
            cnt_d = cnt_q + WIDTH'(1);
          end else begin
            cnt_d = '0;
            y_d   = ~y_q;
            if (!y_q) begin
              tick_d = 1'b1;
            end else begin
              div_d = bus.DIV;
            end
          end
        end
      end

      DRAIN: begin
        if (!y_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!wrap) begin
          cnt_d = cnt_q + WIDTH'(1);
        end else begin
          cnt_d = '0;
          y_d   = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        y_d     = 1'b0;
      end
    endcase

    ack_d = (state_d != IDLE);
  end

  // State and output registers, cleared asynchronously by R
  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      y_q     <= 1'b0;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      y_q     <= y_d;
      tick_q  <= tick_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.Y    = y_q;
  assign bus.TICK = tick_q;
  assign bus.ACK  = ack_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__clkdiv.sv
// Directed testbench for the programmable clock divider.
// Edge k is the k-th rising CLK edge after EN is raised; outputs are sampled
// 1 ns after each edge. SL is the extra enable latency of the synchronizer.
`timescale 1ns/10ps

module tb_gf180mcu_osu_sc_gp9t3v3__clkdiv;

`ifdef GF180MCU_OSU_SC_CLKDIV_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic CLK;
  logic R;
  int   total;
  int   bad;

  gf180mcu_osu_sc_gp9t3v3__clkdiv_if #(.WIDTH(4)) bus ();

  gf180mcu_osu_sc_gp9t3v3__clkdiv #(.WIDTH(4)) dut (
    .CLK (CLK),
    .R   (R),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    R      = 1'b1;
    bus.EN = 1'b0;
    step();
    R = 1'b0;
  endtask

  task automatic test_reset();
    R       = 1'b1;
    bus.EN  = 1'b1;
    bus.DIV = 4'd3;
    #1;
    total++;
    if ({bus.Y, bus.TICK, bus.ACK} !== 3'b000) begin
      bad++;
      $display("FAIL reset_async y/tick/ack=%b need 000", {bus.Y, bus.TICK, bus.ACK});
    end
    step();
    step();
    total++;
    if ({bus.Y, bus.TICK, bus.ACK} !== 3'b000) begin
      bad++;
      $display("FAIL reset_held y/tick/ack=%b need 000", {bus.Y, bus.TICK, bus.ACK});
    end
    bus.EN = 1'b0;
    R      = 1'b0;
    step();
    total++;
    if ({bus.Y, bus.TICK, bus.ACK} !== 3'b000) begin
      bad++;
      $display("FAIL reset_idle y/tick/ack=%b need 000", {bus.Y, bus.TICK, bus.ACK});
    end
  endtask

  // DIV=3: rise at SL+4, fall at SL+8, rise at SL+12
  task automatic test_start();
    logic ey, et, ea;
    bus.DIV = 4'd3;
    bus.EN  = 1'b1;
    for (int k = 0; k <= SL + 13; k++) begin
      step();
      ey = ((k >= SL + 4) && (k < SL + 8)) || (k >= SL + 12);
      et = (k == SL + 4) || (k == SL + 12);
      ea = (k >= SL);
      total++;
      if ({bus.Y, bus.TICK, bus.ACK} !== {ey, et, ea}) begin
        bad++;
        $display("FAIL start edge=%0d y/tick/ack=%b need %b", k,
                 {bus.Y, bus.TICK, bus.ACK}, {ey, et, ea});
      end
    end
  endtask

  // DIV 3->1 while high: fall at SL+8, then rises at SL+10 and SL+14
  task automatic test_ratio_change();
    logic ey, et;
    bus.DIV = 4'd3;
    bus.EN  = 1'b1;
    for (int k = 0; k <= SL + 15; k++) begin
      step();
      ey = ((k >= SL + 4) && (k < SL + 8)) || ((k >= SL + 10) && (k < SL + 12))
           || (k >= SL + 14);
      et = (k == SL + 4) || (k == SL + 10) || (k == SL + 14);
      total++;
      if ({bus.Y, bus.TICK} !== {ey, et}) begin
        bad++;
        $display("FAIL ratio edge=%0d y/tick=%b need %b", k, {bus.Y, bus.TICK}, {ey, et});
      end
      if (k == SL + 5) bus.DIV = 4'd1;
    end
  endtask

  // DIV=2, rise at r; FSM sees en_s low at r+2 so high phase still lasts 3
  task automatic test_stop_high();
    logic ey, et, ea;
    int r;
    r       = SL + 3;
    bus.DIV = 4'd2;
    bus.EN  = 1'b1;
    for (int k = 0; k <= r + 6; k++) begin
      step();
      ey = (k >= r) && (k < r + 3);
      et = (k == r);
      ea = (k >= SL) && (k < r + 4);
      total++;
      if ({bus.Y, bus.TICK, bus.ACK} !== {ey, et, ea}) begin
        bad++;
        $display("FAIL stop_high edge=%0d y/tick/ack=%b need %b", k,
                 {bus.Y, bus.TICK, bus.ACK}, {ey, et, ea});
      end
      if (k == r + 1 - SL) bus.EN = 1'b0;
    end
  endtask

  // DIV=2, en_s low exactly at the edge the first rise is due
  task automatic test_stop_low();
    logic ea;
    int r;
    r       = SL + 3;
    bus.DIV = 4'd2;
    bus.EN  = 1'b1;
    for (int k = 0; k <= r + 4; k++) begin
      step();
      ea = (k >= SL) && (k < r);
      total++;
      if ({bus.Y, bus.TICK, bus.ACK} !== {1'b0, 1'b0, ea}) begin
        bad++;
        $display("FAIL stop_low edge=%0d y/tick/ack=%b need %b", k,
                 {bus.Y, bus.TICK, bus.ACK}, {1'b0, 1'b0, ea});
      end
      if (k == 2) bus.EN = 1'b0;
    end
  endtask

  // Reset asserted between edges in the cycle of a rise (Y=1, TICK=1)
  task automatic test_reset_mid_high();
    bus.DIV = 4'd3;
    bus.EN  = 1'b1;
    for (int k = 0; k <= SL + 4; k++) step();
    total++;
    if ({bus.Y, bus.TICK, bus.ACK} !== 3'b111) begin
      bad++;
      $display("FAIL mid_pre y/tick/ack=%b need 111", {bus.Y, bus.TICK, bus.ACK});
    end
    #3;
    R = 1'b1;
    #1;
    total++;
    if ({bus.Y, bus.TICK, bus.ACK} !== 3'b000) begin
      bad++;
      $display("FAIL mid_reset y/tick/ack=%b need 000", {bus.Y, bus.TICK, bus.ACK});
    end
    step();
    #3;
    R = 1'b0;
    test_start();
  endtask

  // DIV=0: divide-by-2, first rise at SL+1
  task automatic test_div2();
    logic ey;
    bus.DIV = 4'd0;
    bus.EN  = 1'b1;
    for (int k = 0; k <= SL + 9; k++) begin
      step();
      ey = (k >= SL + 1) && (((k - SL - 1) % 2) == 0);
      total++;
      if ({bus.Y, bus.TICK} !== {ey, ey}) begin
        bad++;
        $display("FAIL div2 edge=%0d y/tick=%b need %b", k, {bus.Y, bus.TICK}, {ey, ey});
      end
    end
  endtask

  // DIV=15: divide-by-32, rise SL+16, fall SL+32, rise SL+48
  task automatic test_div_max();
    logic ey, et;
    bus.DIV = 4'd15;
    bus.EN  = 1'b1;
    for (int k = 0; k <= SL + 49; k++) begin
      step();
      ey = ((k >= SL + 16) && (k < SL + 32)) || (k >= SL + 48);
      et = (k == SL + 16) || (k == SL + 48);
      total++;
      if ({bus.Y, bus.TICK} !== {ey, et}) begin
        bad++;
        $display("FAIL div_max edge=%0d y/tick=%b need %b", k, {bus.Y, bus.TICK}, {ey, et});
      end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    R       = 1'b1;
    bus.EN  = 1'b0;
    bus.DIV = '0;
    test_reset();
    do_reset();
    test_start();
    do_reset();
    test_ratio_change();
    do_reset();
    test_stop_high();
    do_reset();
    test_stop_low();
    do_reset();
    test_reset_mid_high();
    do_reset();
    test_div2();
    do_reset();
    test_div_max();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
